// File: rtl/seq_detect_pkg.sv
// Shared types and defaults for the serial pattern-detection controller.
package seq_detect_pkg;

  localparam int MAX_LEN_DEF     = 8;
  localparam int CNT_W_DEF       = 8;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a length field able to hold the value max_len itself.
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Shift register, fill counter and masked pattern compare. The match
// output looks at the shift value that the current bit is about to create,
// so the controller can count a match on the same edge that accepts the bit.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               shift_en,
  input  logic               clr,
  input  logic               fill_clr,
  input  logic               bit_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);

  logic [MAX_LEN-1:0] shift_q;
  logic [MAX_LEN-1:0] shift_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_q;
  logic [LEN_W-1:0]   fill_nxt;

  // Next shift/fill values and the compare over the low len bits.
  always_comb begin
    shift_nxt = {shift_q[MAX_LEN-2:0], bit_in};
    fill_nxt  = (fill_q < len) ? fill_q + LEN_W'(1) : fill_q;
    len_mask  = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (LEN_W'(i) < len);
    end
    match = shift_en && (fill_nxt >= len) &&
            (((shift_nxt ^ pattern) & len_mask) == '0);
  end

  // History register; a non-overlapping match restarts the fill count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      shift_q <= '0;
      fill_q  <= '0;
    end else if (shift_en) begin
      shift_q <= shift_nxt;
      fill_q  <= fill_clr ? '0 : fill_nxt;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run-time configurable serial pattern-detection controller.
// Handshake: a descriptor transfers on a clock edge where cfg_valid and
// cfg_ready are both high; cfg_ready is high only in IDLE and the master
// holds the descriptor stable until that edge.
// Optional watchdog: define SEQ_DETECT_CTRL_TIMEOUT_EN to end a job that
// sees no match for TIMEOUT_CYC consecutive RUN cycles.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN     = MAX_LEN_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int LEN_W      = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic               abort,
  output logic               busy,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               done,
  output logic               timeout,
  output state_e             state_dbg
);

  state_e             state_q;
  state_e             state_d;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_clamped;
  logic               overlap_q;
  logic [CNT_W-1:0]   target_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic               pulse_q;
  logic               done_q;
  logic               run;
  logic               accept;
  logic               shift_en;
  logic               hit;
  logic               target_hit;
  logic               tmo_hit;

  // Handshake, bit qualification (abort blocks the bit) and match counting.
  always_comb begin
    run        = (state_q == RUN);
    accept     = cfg_valid && (state_q == IDLE);
    shift_en   = run && bit_valid && !abort;
    cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    target_hit = hit && (target_q != '0) && (cnt_inc == target_q);
    if (cfg_len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (cfg_len > LEN_W'(MAX_LEN)) begin
      len_clamped = LEN_W'(MAX_LEN);
    end else begin
      len_clamped = cfg_len;
    end
  end

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .shift_en (shift_en),
    .clr      (accept),
    .fill_clr (hit && !overlap_q),
    .bit_in   (bit_in),
    .pattern  (pat_q),
    .len      (len_q),
    .match    (hit)
  );

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             timeout_q;

  assign tmo_hit = run && !abort && !hit &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
  assign timeout = timeout_q;

  // Idle-cycle watchdog: counts RUN cycles since the last match.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_hit;
      if (!run || hit) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: abort beats target completion, which beats the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (target_hit) begin
          state_d = DONE;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cfg_ready = (state_q == IDLE);
    busy      = (state_q == RUN);
    state_dbg = state_q;
  end

  // Descriptor latch, saturating match counter and the one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q     <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      target_q  <= '0;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pulse_q <= hit;
      done_q  <= target_hit;
      if (accept) begin
        pat_q     <= cfg_pattern;
        len_q     <= len_clamped;
        overlap_q <= cfg_overlap;
        target_q  <= cfg_target;
        cnt_q     <= '0;
      end else if (hit) begin
        cnt_q <= cnt_inc;
      end
    end
  end

  assign match_pulse = pulse_q;
  assign match_cnt   = cnt_q;
  assign done        = done_q;

endmodule
